fir_mac_ctrl: RTL and testbench
===============================

# fir_mac_ctrl

Sequencer for the FIR filter's single shared multiply-accumulate unit. On each rising edge of the sample request, it does three things in order: writes the new sample into the circular delay-line RAM, steps the data and coefficient addresses through all taps, then flags the finished result. It sits between the ADC/sample interface and the MAC datapath and RAMs, and holds no data itself, only addresses and strobes.

## Interface
- `TAPS`, 16: filter length; the number of MAC cycles per sample, at least 2.
- `AW`, 4: address width; 2^AW must be at least TAPS.
- `MAC_LAT`, 2: MAC pipeline depth; cycles from the last mac_en until the accumulator is final, at least 0.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `smpl_req`  in  1: sample-request level. Its rising edge starts one frame.
- `ovr_clr`  in  1: clears the sticky overrun flag.
- `wr_en`  out  1: delay-line write strobe.
- `wr_addr`  out  AW: delay-line write address.
- `rd_addr`  out  AW: delay-line read address.
- `coef_addr`  out  AW: coefficient ROM address.
- `mac_en`  out  1: MAC accumulate enable.
- `acc_clr`  out  1: load the accumulator with the product instead of adding.
- `out_vld`  out  1: accumulator result valid, one-cycle pulse.
- `busy`  out  1: a frame is in progress.
- `overrun`  out  1: sticky flag; a request edge was lost.

## Operation
- **Edge detect:** `req_d` is a register of `smpl_req`. `start = smpl_req & ~req_d`, combinational. `req_d` resets to 0, so a request held high through reset release produces a start in the first cycle.
- **Write pointer:** `ptr` is the write pointer, range 0..TAPS-1, reset to 0.
- **All index arithmetic** is modulo TAPS with explicit wrap, not modulo 2^AW, so non-power-of-two TAPS works correctly.
- **FSM states:** IDLE, WRITE, MAC, DRAIN, DONE.
- **IDLE:** all strobes are 0. On `start`, go to WRITE.
- **WRITE (1 cycle):** `wr_en`=1, `wr_addr`=`ptr`. Go to MAC and set k=0.
- **MAC (TAPS cycles, k=0..TAPS-1):**
  - `mac_en`=1, `coef_addr`=k, `rd_addr`=(`ptr`−k) mod TAPS.
  - `acc_clr`=1 only when k=0.
  - After k=TAPS-1, go to DRAIN, or to DONE if MAC_LAT=0.
- **DRAIN (MAC_LAT cycles):** strobes are 0. Then go to DONE.
- **DONE (1 cycle):** `out_vld`=1; `ptr` ← (`ptr`+1) mod TAPS. Then go to IDLE.
- **busy** = (state ≠ IDLE).
- **Address outputs** hold their last value when not in use. They are 0 after reset.
- **Lost request:** a `start` while `busy`=1 (base build) is dropped and sets `overrun`.
- **Clearing overrun:** `ovr_clr` clears `overrun`. If `ovr_clr` and a new overrun occur in the same cycle, set wins.
- **Reset mid-frame:** on the next cycle the state is IDLE; all outputs, `ptr`, `req_d` and `overrun` are 0, and any pending request is discarded.

## Timing
- All outputs are registered from the state, except `busy`, which is a state decode. Reset value of every output is 0.
- With `start` in cycle 0:
  - `wr_en` in cycle 1.
  - `mac_en` in cycles 2..TAPS+1.
  - `out_vld` in cycle TAPS+MAC_LAT+2.
  - `busy` high from cycle 1 through the `out_vld` cycle.
- Minimum request spacing with no overrun is TAPS+MAC_LAT+3 cycles.
- A `start` in the DONE cycle counts as busy (overrun or queued). A `start` in the cycle after DONE begins a new frame.

## Configuration
- `SMPL_QUEUE_EN` defined: a one-entry pending register.
  - A `start` while busy sets `pending` instead of `overrun`.
  - When `pending`=1, DONE goes directly to WRITE and clears `pending`; `ptr` has already advanced.
  - A `start` while busy with `pending` already set sets `overrun`.
- `SMPL_QUEUE_EN` undefined: no pending register. Every `start` while busy sets `overrun` and is discarded.

## Test plan
- **Single frame:** TAPS=4, MAC_LAT=2, reset, then `smpl_req` rises at cycle 0.
  - Cycle 1: `wr_en` with `wr_addr`=0.
  - Cycles 2..5: `mac_en`; `coef_addr` 0,1,2,3; `rd_addr` 0,3,2,1; `acc_clr` only in cycle 2.
  - Cycle 8: `out_vld`. `busy` is high in cycles 1..8.
- **Second frame, TAPS=4:** `wr_addr`=1; `rd_addr` 1,0,3,2; latency is again 8 cycles.
- **Non-power-of-two wrap, TAPS=5, AW=3:** 5th frame gives `wr_addr`=4 and `rd_addr` 4,3,2,1,0; the 6th frame gives `wr_addr`=0. No address ever reaches 5..7.
- **Overrun, base build:**
  - A second rising edge during MAC sets `overrun`=1 the next cycle; only one `out_vld` follows.
  - `smpl_req` held high for 20 cycles produces exactly one frame.
  - `ovr_clr` together with a new overrun leaves `overrun`=1.
- **Queue, `SMPL_QUEUE_EN` defined, TAPS=4:** an edge at cycle 4 gives `out_vld` at cycle 8 and `wr_en` at cycle 9 with `wr_addr`=1; `overrun` stays 0. A third edge during that time sets `overrun`=1.
- **Reset mid-MAC (cycle 3):**
  - The next cycle all outputs are 0 and `busy`=0; no `out_vld` occurs.
  - The following request writes `wr_addr`=0.

Source files
------------

// File: rtl/fir_mac_ctrl.sv
// Address/strobe sequencer for a single shared FIR multiply-accumulate unit.
// Optional build macro SMPL_QUEUE_EN adds a one-entry pending-request register.
module fir_mac_ctrl #(
    parameter int TAPS    = 16,
    parameter int AW      = 4,
    parameter int MAC_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          smpl_req,
    input  logic          ovr_clr,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic [AW-1:0] coef_addr,
    output logic          mac_en,
    output logic          acc_clr,
    output logic          out_vld,
    output logic          busy,
    output logic          overrun
);

    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_MAC, S_DRAIN, S_DONE} state_t;

    state_t          r_state;
    logic            r_req_d;
    logic [AW-1:0]   r_ptr;
    logic [AW-1:0]   r_wr_addr;
    logic [AW-1:0]   r_rd_addr;
    logic [AW-1:0]   r_coef_addr;
    logic [DW-1:0]   r_drain;
    logic            r_wr_en;
    logic            r_mac_en;
    logic            r_acc_clr;
    logic            r_out_vld;
    logic            r_overrun;

    logic            w_start;
    logic            w_busy;
    logic            w_ovr_set;
    logic            w_go;
    logic            w_requeue;
    logic [AW-1:0]   w_ptr_inc;
    logic [AW-1:0]   w_rd_dec;

    assign w_start   = smpl_req & ~r_req_d;
    assign w_busy    = (r_state != S_IDLE);
    // Wrap at TAPS rather than 2^AW so odd filter lengths stay in range.
    assign w_ptr_inc = (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
    assign w_rd_dec  = (r_rd_addr == '0) ? LAST : r_rd_addr - 1'b1;

`ifdef SMPL_QUEUE_EN
    logic r_pending;
    assign w_ovr_set = w_start & w_busy & r_pending;
    assign w_go      = w_start | r_pending;
    assign w_requeue = r_pending;
`else
    assign w_ovr_set = w_start & w_busy;
    assign w_go      = w_start;
    assign w_requeue = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_req_d     <= 1'b0;
            r_ptr       <= '0;
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_coef_addr <= '0;
            r_drain     <= '0;
            r_wr_en     <= 1'b0;
            r_mac_en    <= 1'b0;
            r_acc_clr   <= 1'b0;
            r_out_vld   <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef SMPL_QUEUE_EN
            r_pending   <= 1'b0;
`endif
        end else begin
            r_req_d   <= smpl_req;
            r_wr_en   <= 1'b0;
            r_mac_en  <= 1'b0;
            r_acc_clr <= 1'b0;
            r_out_vld <= 1'b0;

            if (w_ovr_set)
                r_overrun <= 1'b1;
            else if (ovr_clr)
                r_overrun <= 1'b0;

`ifdef SMPL_QUEUE_EN
            if (w_start && w_busy && !r_pending)
                r_pending <= 1'b1;
`endif

            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state   <= S_WRITE;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_ptr;
`ifdef SMPL_QUEUE_EN
                        r_pending <= 1'b0;
`endif
                    end
                end
                S_WRITE: begin
                    r_state     <= S_MAC;
                    r_mac_en    <= 1'b1;
                    r_acc_clr   <= 1'b1;
                    r_coef_addr <= '0;
                    r_rd_addr   <= r_ptr;
                end
                S_MAC: begin
                    if (r_coef_addr == LAST) begin
                        if (MAC_LAT == 0) begin
                            r_state   <= S_DONE;
                            r_out_vld <= 1'b1;
                        end else begin
                            r_state <= S_DRAIN;
                            r_drain <= DW'(MAC_LAT - 1);
                        end
                    end else begin
                        r_mac_en    <= 1'b1;
                        r_coef_addr <= r_coef_addr + 1'b1;
                        r_rd_addr   <= w_rd_dec;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == '0) begin
                        r_state   <= S_DONE;
                        r_out_vld <= 1'b1;
                    end else begin
                        r_drain <= r_drain - 1'b1;
                    end
                end
                S_DONE: begin
                    r_ptr <= w_ptr_inc;
                    // A queued request launches straight from DONE with the advanced pointer.
                    if (w_requeue) begin
                        r_state   <= S_WRITE;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_ptr_inc;
`ifdef SMPL_QUEUE_EN
                        r_pending <= 1'b0;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign rd_addr   = r_rd_addr;
    assign coef_addr = r_coef_addr;
    assign mac_en    = r_mac_en;
    assign acc_clr   = r_acc_clr;
    assign out_vld   = r_out_vld;
    assign busy      = w_busy;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Bench for fir_mac_ctrl: a TAPS=4 and a TAPS=5 (AW=3) instance share stimulus and
// are checked every cycle against a frame-schedule model plus directed literals.
module tb_fir_mac_ctrl;

    localparam int LAT = 2;

    logic clk;
    logic reset;
    logic smpl_req;
    logic ovr_clr;
    int   cyc;

    logic       wr_en4, mac_en4, acc_clr4, out_vld4, busy4, overrun4;
    logic [3:0] wr_addr4, rd_addr4, coef_addr4;
    logic       wr_en5, mac_en5, acc_clr5, out_vld5, busy5, overrun5;
    logic [2:0] wr_addr5, rd_addr5, coef_addr5;

    fir_mac_ctrl #(.TAPS(4), .AW(4), .MAC_LAT(LAT)) u_dut4 (
        .clk(clk), .reset(reset), .smpl_req(smpl_req), .ovr_clr(ovr_clr),
        .wr_en(wr_en4), .wr_addr(wr_addr4), .rd_addr(rd_addr4), .coef_addr(coef_addr4),
        .mac_en(mac_en4), .acc_clr(acc_clr4), .out_vld(out_vld4), .busy(busy4),
        .overrun(overrun4)
    );

    fir_mac_ctrl #(.TAPS(5), .AW(3), .MAC_LAT(LAT)) u_dut5 (
        .clk(clk), .reset(reset), .smpl_req(smpl_req), .ovr_clr(ovr_clr),
        .wr_en(wr_en5), .wr_addr(wr_addr5), .rd_addr(rd_addr5), .coef_addr(coef_addr5),
        .mac_en(mac_en5), .acc_clr(acc_clr5), .out_vld(out_vld5), .busy(busy5),
        .overrun(overrun5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: a frame accepted in cycle s has wr_en at s+1, MACs at s+2..s+T+1,
    // out_vld at s+T+LAT+2 and is busy over s+1..s+T+LAT+2.
    int          m_T [2] = '{4, 5};
    bit          m_reqd [2];
    int          m_ptr [2];
    bit          m_ovr [2];
    bit          m_act [2];
    int          m_s [2];
    int          m_fp [2];
    bit          m_pend [2];
    int          m_wa [2];
    int          m_ra [2];
    int          m_ca [2];
    logic [16:0] m_exp [2];
    bit          model_ok = 0;

    task automatic model_step(input int d);
        int  t, f, n, o, k;
        bit  start, busy_n, done_n, set_ovr, launch, we, mac, clr, vld, bsy;
        t = m_T[d];
        f = t + LAT + 2;
        n = cyc;
        if (reset) begin
            m_reqd[d] = 0; m_ptr[d] = 0; m_ovr[d] = 0; m_act[d] = 0;
            m_pend[d] = 0; m_wa[d] = 0; m_ra[d] = 0; m_ca[d] = 0;
            m_exp[d] = '0;
            return;
        end
        start     = smpl_req && !m_reqd[d];
        m_reqd[d] = smpl_req;
        busy_n    = m_act[d] && (n > m_s[d]) && (n <= m_s[d] + f);
        done_n    = m_act[d] && (n == m_s[d] + f);
        set_ovr   = 0;
        launch    = 0;
        if (done_n) m_ptr[d] = (m_fp[d] + 1) % t;
`ifdef SMPL_QUEUE_EN
        begin
            bit pend_old;
            pend_old = m_pend[d];
            if (start && busy_n) begin
                if (pend_old) set_ovr = 1;
                else m_pend[d] = 1;
            end
            if (done_n && pend_old) begin
                launch = 1; m_pend[d] = 0;
            end else if (!busy_n && (start || pend_old)) begin
                launch = 1; m_pend[d] = 0;
            end
        end
`else
        if (start && busy_n) set_ovr = 1;
        else if (start) launch = 1;
`endif
        if (launch) begin
            m_act[d] = 1; m_s[d] = n; m_fp[d] = m_ptr[d];
        end else if (done_n) begin
            m_act[d] = 0;
        end
        if (set_ovr) m_ovr[d] = 1;
        else if (ovr_clr) m_ovr[d] = 0;

        o   = m_act[d] ? (n + 1 - m_s[d]) : -1;
        we  = (o == 1);
        mac = (o >= 2) && (o <= t + 1);
        clr = (o == 2);
        vld = (o == f);
        bsy = (o >= 1) && (o <= f);
        if (we) m_wa[d] = m_fp[d];
        if (mac) begin
            k = o - 2;
            m_ca[d] = k;
            m_ra[d] = (m_fp[d] - k + t) % t;
        end
        m_exp[d] = {we, 4'(m_wa[d]), 4'(m_ra[d]), 4'(m_ca[d]), mac, clr, vld, bsy, m_ovr[d]};
    endtask

    logic [16:0] v4, v5;
    assign v4 = {wr_en4, wr_addr4, rd_addr4, coef_addr4, mac_en4, acc_clr4, out_vld4, busy4, overrun4};
    assign v5 = {wr_en5, 1'b0, wr_addr5, 1'b0, rd_addr5, 1'b0, coef_addr5,
                 mac_en5, acc_clr5, out_vld5, busy5, overrun5};

    int max_addr5 = 0;

    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_taps4", int'(v4), int'(m_exp[0]));
            chk("model_taps5", int'(v5), int'(m_exp[1]));
        end
        model_step(0);
        model_step(1);
        if (reset) model_ok = 1;
        if (!reset) begin
            if (int'(wr_addr5) > max_addr5)   max_addr5 = int'(wr_addr5);
            if (int'(rd_addr5) > max_addr5)   max_addr5 = int'(rd_addr5);
            if (int'(coef_addr5) > max_addr5) max_addr5 = int'(coef_addr5);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int          cap_wa4, cap_wa5, cap_vld4, cap_vld5, cap_clr4, cap_busy4;
    logic [15:0] cap_rd4;
    logic [19:0] cap_rd5;

    // One request edge at cycle 0, then observe cycles 1..14.
    task automatic do_frame();
        cap_wa4 = -1; cap_wa5 = -1; cap_vld4 = -1; cap_vld5 = -1;
        cap_clr4 = -1; cap_busy4 = 0; cap_rd4 = '0; cap_rd5 = '0;
        smpl_req = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 1) smpl_req = 1'b0;
            if (wr_en4)   cap_wa4 = int'(wr_addr4);
            if (wr_en5)   cap_wa5 = int'(wr_addr5);
            if (mac_en4)  cap_rd4 = {cap_rd4[11:0], rd_addr4};
            if (mac_en5)  cap_rd5 = {cap_rd5[15:0], 1'b0, rd_addr5};
            if (out_vld4) cap_vld4 = c;
            if (out_vld5) cap_vld5 = c;
            if (acc_clr4) cap_clr4 = c;
            if (busy4)    cap_busy4++;
        end
    endtask

    int vc;

    initial begin
        reset = 1'b1; smpl_req = 1'b0; ovr_clr = 1'b0; cyc = 0;
        tick(3);
        chk("reset_busy", int'(busy4), 0);
        chk("reset_outputs", int'(v4), 0);
        reset = 1'b0;
        tick(2);

        do_frame();
        chk("f1_wr_addr", cap_wa4, 0);
        chk("f1_rd_seq", int'(cap_rd4), 'h0321);
        chk("f1_acc_clr_cycle", cap_clr4, 2);
        chk("f1_vld_cycle", cap_vld4, 8);
        chk("f1_busy_cycles", cap_busy4, 8);
        chk("f1_t5_rd_seq", int'(cap_rd5), 'h04321);
        chk("f1_t5_vld_cycle", cap_vld5, 9);

        do_frame();
        chk("f2_wr_addr", cap_wa4, 1);
        chk("f2_rd_seq", int'(cap_rd4), 'h1032);
        chk("f2_vld_cycle", cap_vld4, 8);

        do_frame();
        do_frame();
        do_frame();
        chk("f5_t5_wr_addr", cap_wa5, 4);
        chk("f5_t5_rd_seq", int'(cap_rd5), 'h43210);
        do_frame();
        chk("f6_t5_wr_addr", cap_wa5, 0);
        chk("t5_max_addr", max_addr5, 4);

`ifndef SMPL_QUEUE_EN
        // Second edge during MAC.
        smpl_req = 1'b1; tick();
        smpl_req = 1'b0; tick(3);
        smpl_req = 1'b1; tick();
        chk("ovr_set_next", int'(overrun4), 1);
        smpl_req = 1'b0;
        vc = 0;
        repeat (14) begin tick(); if (out_vld4) vc++; end
        chk("ovr_single_vld", vc, 1);
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        chk("ovr_cleared", int'(overrun4), 0);

        // Clear and set in the same cycle.
        smpl_req = 1'b1; tick();
        smpl_req = 1'b0; tick(3);
        smpl_req = 1'b1; ovr_clr = 1'b1; tick();
        chk("ovr_set_wins", int'(overrun4), 1);
        smpl_req = 1'b0; ovr_clr = 1'b0;
        tick(14);
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
`else
        reset = 1'b1; tick(); reset = 1'b0; tick();
        smpl_req = 1'b1; tick();
        smpl_req = 1'b0; tick(3);
        smpl_req = 1'b1; tick();
        chk("q_no_overrun", int'(overrun4), 0);
        smpl_req = 1'b0; tick();
        smpl_req = 1'b1; tick();
        chk("q_third_overrun", int'(overrun4), 1);
        smpl_req = 1'b0; tick();
        chk("q_vld_c8", int'(out_vld4), 1);
        tick();
        chk("q_wr_en_c9", int'(wr_en4), 1);
        chk("q_wr_addr_c9", int'(wr_addr4), 1);
        tick(14);
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
`endif

        // Request held high: one edge, one frame.
        smpl_req = 1'b1;
        vc = 0;
        repeat (20) begin tick(); if (out_vld4) vc++; end
        smpl_req = 1'b0;
        repeat (12) begin tick(); if (out_vld4) vc++; end
        chk("held_req_one_frame", vc, 1);

        // Reset during MAC.
        smpl_req = 1'b1; tick();
        smpl_req = 1'b0; tick(2);
        reset = 1'b1; tick();
        chk("midrst_outputs", int'(v4), 0);
        chk("midrst_busy", int'(busy5), 0);
        reset = 1'b0;
        vc = 0;
        repeat (12) begin tick(); if (out_vld4 || out_vld5) vc++; end
        chk("midrst_no_vld", vc, 0);
        do_frame();
        chk("midrst_wr_addr4", cap_wa4, 0);
        chk("midrst_wr_addr5", cap_wa5, 0);

        tick(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
